execute_muldiv: RTL and testbench



---
 rtl/execute_muldiv_pkg.sv | 47 ++++
 rtl/muldiv_divider.sv | 103 ++++++++++
 rtl/execute_muldiv.sv | 220 ++++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/execute_muldiv_pkg.sv
// rtl/execute_muldiv_pkg.sv - shared types for the execute-stage multiply/divide unit
//
// Purpose: decoded ALU function enum, multiply/divide FSM states, XLEN-derived
// word types and the 32-bit extension helpers used for the W-variants.
// Ports: none (package).
package execute_muldiv_pkg;

  localparam int DATA_W = 64;
  localparam int WORD_W = 32;

  typedef logic [DATA_W-1:0] u64_t;
  typedef logic [WORD_W-1:0] u32_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIV  = 4'd11,
    ALU_DIVU = 4'd12,
    ALU_MOD  = 4'd13,
    ALU_MODU = 4'd14
  } alu_func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic u64_t sext32(input u32_t v);
    return {{(DATA_W-WORD_W){v[WORD_W-1]}}, v};
  endfunction

  function automatic u64_t zext32(input u32_t v);
    return {{(DATA_W-WORD_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// rtl/muldiv_divider.sv - iterative restoring unsigned divider, one quotient bit per cycle
//
// Purpose: unsigned dividend/divisor in, quotient/remainder out after
// iter_count cycles. Sign handling and special cases live in the parent.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             load operands and begin (one cycle pulse)
//   flush             abandon the division in progress
//   iter_count        number of quotient bits to produce (32 or XLEN)
//   dividend, divisor unsigned operands (word operands in the low 32 bits)
//   done              high during the last iteration cycle
//   quotient,remainder values produced by the current iteration (valid with done)
module muldiv_divider #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [CNT_W-1:0] iter_count,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  output logic             done,
  output logic [XLEN-1:0]  quotient,
  output logic [XLEN-1:0]  remainder
);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dsr_q, dsr_d;

  logic [CNT_W-1:0] align_sh;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  quo_step;
  logic [XLEN-1:0]  rem_step;

  // A short (word) division consumes only its top iter_count dividend bits,
  // so the dividend is pre-aligned to the MSB end of the shift register.
  assign align_sh = CNT_W'(XLEN) - iter_count;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while new quotient bits enter at the LSB.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};

  always_comb begin
    quo_step = {quo_q[XLEN-2:0], 1'b0};
    rem_step = rem_sh[XLEN-1:0];
    if (!diff[XLEN]) begin
      quo_step = {quo_q[XLEN-2:0], 1'b1};
      rem_step = diff[XLEN-1:0];
    end
  end

  assign done      = active_q && (cnt_q == CNT_W'(1));
  assign quotient  = quo_step;
  assign remainder = rem_step;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    if (flush) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = iter_count;
      quo_d    = dividend << align_sh;
      rem_d    = '0;
      dsr_d    = divisor;
    end else if (active_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      quo_d = quo_step;
      rem_d = rem_step;
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - multi-cycle multiply/divide unit of the execute stage
//
// Purpose: shift-add multiply and restoring divide, one bit per cycle, with
// RV64 W-variant handling, divide-by-zero / signed-overflow shortcuts and a
// valid/ready result handshake that stalls the pipeline while busy.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operation offered / unit idle and able to accept
//   func, word           decoded ALU function and W-variant flag
//   srca, srcb           rs1 / rs2 values, captured only at accept
//   flush                squash any operation in flight
//   out_valid/out_ready  result available / consumer takes it
//   result               product low half, quotient or remainder
//   busy                 stall request (unit not idle)
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int XLEN  = DATA_W,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_func_t       func,
  input  logic            word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  // W-variants deliver the sign-extended low word, even for unsigned ops.
  function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
    return w ? sext32(v[31:0]) : v;
  endfunction

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  prod_q, prod_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             word_q, word_d;
  logic             sel_rem_q, sel_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             is_mul, is_div, is_signed, is_rem;
  logic [XLEN-1:0]  op_a, op_b, abs_a, abs_b, most_neg, special_res;
  logic             sign_a, sign_b, div_zero, div_ovf, special, accept;
  logic [CNT_W-1:0] n_iter;

  logic [XLEN-1:0]  prod_step;
  logic             mul_last;
  logic             div_start, div_done;
  logic [XLEN-1:0]  div_quo, div_rem, quo_signed, rem_signed;

  // Decode and operand conditioning, all evaluated in the accept cycle.
  assign is_mul    = (func == ALU_MUL);
  assign is_div    = func inside {ALU_DIV, ALU_DIVU, ALU_MOD, ALU_MODU};
  assign is_signed = func inside {ALU_DIV, ALU_MOD};
  assign is_rem    = func inside {ALU_MOD, ALU_MODU};

  assign op_a = !word ? srca : (is_signed ? sext32(srca[31:0]) : zext32(srca[31:0]));
  assign op_b = !word ? srcb : (is_signed ? sext32(srcb[31:0]) : zext32(srcb[31:0]));

  assign n_iter = word ? CNT_W'(32) : CNT_W'(XLEN);

  assign sign_a = is_signed & op_a[XLEN-1];
  assign sign_b = is_signed & op_b[XLEN-1];
  assign abs_a  = sign_a ? -op_a : op_a;
  assign abs_b  = sign_b ? -op_b : op_b;

  // Word operands are already sign-extended, so the 32-bit most-negative value
  // and -1 compare correctly against their 64-bit extended forms.
  assign most_neg = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (op_b == '0);
  assign div_ovf  = is_signed && (op_a == most_neg) && (op_b == '1);
  assign special  = is_div && (div_zero || div_ovf);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = is_rem ? fix_word(word, op_a) : '1;
    end else begin
      special_res = is_rem ? '0 : fix_word(word, op_a);
    end
  end

  // Flush outranks accept, and unknown functions are simply not taken.
  assign accept = in_valid && in_ready && !flush && (is_mul || is_div);

  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign mul_last  = (state_q == MUL) && (cnt_q == CNT_W'(1));

  assign div_start  = accept && is_div && !special;
  assign quo_signed = neg_quo_q ? -div_quo : div_quo;
  assign rem_signed = neg_rem_q ? -div_rem : div_rem;

  muldiv_divider #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .start      (div_start),
    .flush      (flush),
    .iter_count (n_iter),
    .dividend   (abs_a),
    .divisor    (abs_b),
    .done       (div_done),
    .quotient   (div_quo),
    .remainder  (div_rem)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = special ? DONE : (is_mul ? MUL : DIV);
          end
        end
        MUL:     if (mul_last)  state_d = DONE;
        DIV:     if (div_done)  state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  assign result = result_q;

  // Datapath: operand capture, multiply iteration and final result fix-up.
  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    result_d  = result_q;
    word_d    = word_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (!flush) begin
      if (accept) begin
        word_d    = word;
        sel_rem_d = is_rem;
        neg_quo_d = sign_a ^ sign_b;
        neg_rem_d = sign_a;
        cnt_d     = n_iter;
        mcand_d   = op_a;
        mplier_d  = op_b;
        prod_d    = '0;
        if (special) begin
          result_d = special_res;
        end
      end else if (state_q == MUL) begin
        cnt_d    = cnt_q - CNT_W'(1);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        prod_d   = prod_step;
        if (mul_last) begin
          result_d = fix_word(word_q, prod_step);
        end
      end else if ((state_q == DIV) && div_done) begin
        result_d = fix_word(word_q, sel_rem_q ? rem_signed : quo_signed);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      result_q  <= '0;
      word_q    <= 1'b0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
      word_q    <= word_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// tb/tb_execute_muldiv.sv - directed self-checking bench for execute_muldiv
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  alu_func_t   func;
  logic        word;
  logic [63:0] srca;
  logic [63:0] srcb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .word      (word),
    .srca      (srca),
    .srcb      (srcb),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one op for a single cycle, scramble the inputs afterwards, measure
  // edges from accept to out_valid, check the result and release it.
  task automatic run_op(input string tag, input alu_func_t f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] res);
    int cyc;
    func = f; word = w; srca = a; srcb = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0; srca = '1; srcb = '0; func = ALU_ADD; word = ~w;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " result"}, result, res);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " idle after take"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; in_valid = 1'b0; func = ALU_ADD; word = 1'b0;
    srca = '0; srcb = '0; flush = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset result", result, 64'd0);
    reset = 1'b0;
    step();

    run_op("mul 7*-3", ALU_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("divw -7/2", ALU_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("modw -7%2", ALU_MOD, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divu by 0", ALU_DIVU, 1'b0, 64'h1234, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("modu by 0", ALU_MODU, 1'b0, 64'h1234, 64'd0, 1, 64'h1234);
    run_op("div ovf", ALU_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000);
    run_op("mod ovf", ALU_MOD, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
    run_op("div -100/7", ALU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("mod -100%7", ALU_MOD, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divuw sext", ALU_DIVU, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'hABCD_0000_0000_0001, 33, 64'hFFFF_FFFF_FFFF_FFF0);
    run_op("mulw", ALU_MUL, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 33, 64'hFFFF_FFFF_8000_0000);

    // Non-muldiv function is ignored.
    func = ALU_ADD; word = 1'b0; srca = 64'd1; srcb = 64'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ignored func busy", {63'd0, busy}, 64'd0);
    chk("ignored func in_ready", {63'd0, in_ready}, 64'd1);

    // Result held in DONE while the consumer stalls.
    func = ALU_DIVU; srca = 64'h64; srcb = 64'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold result", result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("hold in_ready", {63'd0, in_ready}, 64'd0);
      step();
    end
    // New op offered in the same cycle the result is taken: not accepted yet.
    out_ready = 1'b1; in_valid = 1'b1; func = ALU_MODU; srca = 64'h55; srcb = 64'd0;
    step();
    out_ready = 1'b0;
    chk("take then idle", {63'd0, in_ready}, 64'd1);
    chk("take out_valid low", {63'd0, out_valid}, 64'd0);
    step();
    in_valid = 1'b0;
    chk("next op out_valid", {63'd0, out_valid}, 64'd1);
    chk("next op result", result, 64'h55);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush at iteration 20 of a divide.
    func = ALU_DIV; srca = 64'd1000; srcb = 64'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (19) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("flush no result", {63'd0, seen}, 64'd0);

    // Reset in the middle of a multiply.
    func = ALU_MUL; srca = 64'd5; srcb = 64'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("mid mul busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    chk("mid reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid reset busy", {63'd0, busy}, 64'd0);
    chk("mid reset result", result, 64'd0);
    reset = 1'b0;
    step();

    run_op("mul after reset", ALU_MUL, 1'b0, 64'd5, 64'd6, 65, 64'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
